gth_rx_reset_sequencer: RTL and testbench
=========================================

GTH_RX_RESET_SEQUENCER -- requirements
Module: gth_rx_reset_sequencer

Interface
REQ-001 Parameter N_CH, default 8: number of GTH RX channels sharing one refclk PLL.
REQ-002 Parameter RST_CYCLES, default 16: width in clk cycles of every reset pulse.
REQ-003 Parameter LOCK_TIMEOUT, default 1024: maximum clk cycles spent waiting for PLL lock.
REQ-004 Parameter DONE_TIMEOUT, default 1024: maximum clk cycles spent waiting for all RX resetdone flags.
REQ-005 Parameter MAX_RETRY, default 3: number of restarts allowed before the block declares a fault.
REQ-006 clk  in  1  single clock; all logic is on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request that begins a sequence.
REQ-009 pll_lock  in  1  PLL lock status, already synchronized to clk.
REQ-010 rx_resetdone  in  N_CH  per-channel RX reset done, already synchronized to clk.
REQ-011 pll_reset  out  1  PLL reset to the GTH common/channel PLL.
REQ-012 rx_reset  out  N_CH  per-channel GTH RX reset.
REQ-013 ready  out  1  high while all channels are up.
REQ-014 fault  out  1  high once the retry budget is exhausted.
REQ-015 retry_cnt  out  2  number of retries taken in the current sequence.
REQ-016 state  out  3  current FSM state code, for debug.

Function
REQ-017 FSM states and codes SHALL be: IDLE=0, PLL_RST=1, WAIT_LOCK=2, RX_RST=3, WAIT_DONE=4, READY=5, FAULT=6.
REQ-018 In IDLE, start=1 SHALL move the FSM to PLL_RST on the next edge; in any other state except FAULT, start SHALL be ignored.
REQ-019 In PLL_RST, pll_reset SHALL be 1 for exactly RST_CYCLES cycles and rx_reset SHALL be all-ones; the FSM then enters WAIT_LOCK.
REQ-020 In WAIT_LOCK, rx_reset SHALL stay all-ones and a cycle counter SHALL run from 0; pll_lock=1 SHALL move the FSM to RX_RST.
REQ-021 In WAIT_LOCK, if the counter reaches LOCK_TIMEOUT-1 with pll_lock=0, the FSM SHALL take the retry path.
REQ-022 In RX_RST, rx_reset SHALL be all-ones for exactly RST_CYCLES cycles, then the FSM enters WAIT_DONE with rx_reset=0.
REQ-023 In WAIT_DONE, &rx_resetdone=1 SHALL move the FSM to READY; reaching DONE_TIMEOUT-1 cycles first SHALL take the retry path.
REQ-024 In WAIT_DONE, pll_lock=0 SHALL take the retry path immediately.
REQ-025 Retry path: if retry_cnt<MAX_RETRY, retry_cnt increments and the FSM enters PLL_RST; otherwise the FSM enters FAULT.
REQ-026 READY SHALL drive ready=1; pll_lock=0 in READY SHALL clear retry_cnt, drop ready the next cycle and enter PLL_RST (loss-of-lock recovery).
REQ-027 FAULT SHALL drive fault=1, pll_reset=1 and rx_reset all-ones; start=1 SHALL clear retry_cnt and fault and enter PLL_RST.
REQ-028 retry_cnt SHALL clear on each IDLE->PLL_RST transition and SHALL saturate at MAX_RETRY.
REQ-029 The phase counter SHALL be wide enough for max(RST_CYCLES, LOCK_TIMEOUT, DONE_TIMEOUT), SHALL reset to 0 on every state change and SHALL never wrap.
REQ-030 All outputs SHALL be registered; a state change is visible on the outputs in the same cycle as the state register.

Reset
REQ-031 rst=1 SHALL, at any time including mid-sequence, force state=IDLE, pll_reset=1, rx_reset all-ones, ready=0, fault=0, retry_cnt=0, counter=0.
REQ-032 rst SHALL take priority over start and all status inputs in the same cycle.

Verification
REQ-033 start at cycle 0; pll_lock rises 50 cycles after pll_reset falls; rx_resetdone=0xFF 20 cycles after rx_reset falls -> pll_reset high 16 cycles, rx_reset high 16 cycles in RX_RST, ready=1, retry_cnt=0.
REQ-034 start with pll_lock held at 0 -> four PLL_RST pulses (initial plus 3 retries) 1024 cycles apart in WAIT_LOCK, then fault=1, state=6, retry_cnt=3.
REQ-035 In WAIT_DONE, rx_resetdone=0x7F held -> timeout after 1024 cycles, retry_cnt=1, new PLL_RST; then 0xFF -> ready=1.
REQ-036 In READY, pll_lock pulsed low for 1 cycle -> ready=0 next cycle, state=1, retry_cnt=0, full resequence completes.
REQ-037 rst asserted in RX_RST at counter=8 -> next cycle state=0, rx_reset=0xFF, pll_reset=1; start while state=2 -> no effect.

Source files
------------

// File: rtl/gth_rx_reset_sequencer.sv
// GTH RX reset sequencer: PLL reset, lock wait, per-channel RX reset,
// resetdone wait, bounded retries, loss-of-lock recovery and fault latch.
module gth_rx_reset_sequencer #(
    parameter int N_CH         = 8,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int DONE_TIMEOUT = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            pll_lock,
    input  logic [N_CH-1:0] rx_resetdone,
    output logic            pll_reset,
    output logic [N_CH-1:0] rx_reset,
    output logic            ready,
    output logic            fault,
    output logic [1:0]      retry_cnt,
    output logic [2:0]      state
);

    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > DONE_TIMEOUT) ? MAX_A : DONE_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(MAX_CNT);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLL_RST   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_RX_RST    = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_READY     = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t          state_q;
    state_t          state_n;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_n;
    logic [1:0]      retry_n;
    logic            retry_take;
    logic            pll_reset_n;
    logic [N_CH-1:0] rx_reset_n;
    logic            ready_n;
    logic            fault_n;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            rx_reset  <= '1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            retry_cnt <= retry_n;
            pll_reset <= pll_reset_n;
            rx_reset  <= rx_reset_n;
            ready     <= ready_n;
            fault     <= fault_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        retry_n    = retry_cnt;
        retry_take = 1'b0;
        cnt_n      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_PLL_RST;
                    retry_n = '0;
                end
            end
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (pll_lock) state_n = S_RX_RST;
                else if (cnt_q == LOCK_LAST) retry_take = 1'b1;
            end
            S_RX_RST: begin
                if (cnt_q == RST_LAST) state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Losing lock invalidates the RX reset, so it wins over resetdone.
                if (!pll_lock) retry_take = 1'b1;
                else if (&rx_resetdone) state_n = S_READY;
                else if (cnt_q == DONE_LAST) retry_take = 1'b1;
            end
            S_READY: begin
                if (!pll_lock) begin
                    state_n = S_PLL_RST;
                    retry_n = '0;
                end
            end
            S_FAULT: begin
                if (start) begin
                    state_n = S_PLL_RST;
                    retry_n = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (retry_take) begin
            if (retry_cnt < RETRY_MAX) begin
                retry_n = retry_cnt + 2'd1;
                state_n = S_PLL_RST;
            end else begin
                state_n = S_FAULT;
            end
        end

        if (state_n != state_q) cnt_n = '0;

        // Outputs are decoded from the next state so they move with the state register.
        pll_reset_n = 1'b0;
        rx_reset_n  = '0;
        ready_n     = 1'b0;
        fault_n     = 1'b0;
        unique case (state_n)
            S_IDLE: begin
                pll_reset_n = 1'b1;
                rx_reset_n  = '1;
            end
            S_PLL_RST: begin
                pll_reset_n = 1'b1;
                rx_reset_n  = '1;
            end
            S_WAIT_LOCK: rx_reset_n = '1;
            S_RX_RST:    rx_reset_n = '1;
            S_WAIT_DONE: rx_reset_n = '0;
            S_READY:     ready_n    = 1'b1;
            S_FAULT: begin
                pll_reset_n = 1'b1;
                rx_reset_n  = '1;
                fault_n     = 1'b1;
            end
            default: begin
                pll_reset_n = 1'b1;
                rx_reset_n  = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_gth_rx_reset_sequencer.sv
// Bench for gth_rx_reset_sequencer: a reactive PLL/transceiver model plus
// per-attempt timing arithmetic that predicts the sequencer's outcome.
module tb_gth_rx_reset_sequencer;

    localparam int N_CH = 8;
    localparam int RSTC = 16;
    localparam int LT   = 1024;
    localparam int DT   = 1024;
    localparam int BOUND = 12000;

    typedef int arr4_t[4];

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            pll_lock;
    logic [N_CH-1:0] rx_resetdone;
    logic            pll_reset;
    logic [N_CH-1:0] rx_reset;
    logic            ready;
    logic            fault;
    logic [1:0]      retry_cnt;
    logic [2:0]      state;

    int total = 0;
    int bad   = 0;

    // environment: PLL locks lk_a[i] cycles after reset release on attempt i,
    // all channels report done dn_a[i] cycles after RX reset release
    arr4_t     lk_a;
    arr4_t     dn_a;
    logic [N_CH-1:0] mask;
    int s_cnt, rs_cnt, falls;
    bit was_rst;

    gth_rx_reset_sequencer #(
        .N_CH(N_CH), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LT),
        .DONE_TIMEOUT(DT), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pll_lock(pll_lock),
        .rx_resetdone(rx_resetdone), .pll_reset(pll_reset),
        .rx_reset(rx_reset), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int idx;
        @(posedge clk);
        @(negedge clk);
        if (pll_reset) begin
            s_cnt = 0;
            was_rst = 1'b1;
        end else begin
            if (was_rst) begin
                falls++;
                was_rst = 1'b0;
            end
            s_cnt++;
        end
        if (rx_reset[0]) rs_cnt = 0;
        else rs_cnt++;
        idx = (falls == 0) ? 0 : ((falls > 4) ? 3 : falls - 1);
        pll_lock = !pll_reset && (s_cnt > lk_a[idx]);
        rx_resetdone = (!rx_reset[0] && rs_cnt > dn_a[idx]) ? '1 : mask;
    endtask

    // one attempt = PLL reset, lock wait, RX reset, done wait; retries re-run it
    function automatic void predict(input arr4_t lk, input arr4_t dn,
                                    output int t, output bit ok, output int rc,
                                    output int ph, output int rh);
        t = 0; ok = 0; rc = 3; ph = 0; rh = 0;
        for (int a = 0; a < 4; a++) begin
            if (!ok) begin
                ph += RSTC;
                rh += RSTC;
                t  += RSTC;
                if (lk[a] < LT) begin
                    t  += lk[a] + 1 + RSTC;
                    rh += lk[a] + 1 + RSTC;
                    if (dn[a] < DT) begin
                        t += dn[a] + 1;
                        ok = 1;
                        rc = a;
                    end else begin
                        t += DT;
                    end
                end else begin
                    t  += LT;
                    rh += LT;
                end
            end
        end
    endfunction

    // called on the first cycle observed in PLL_RST
    task automatic run_seq(input string tag, input arr4_t lk, input arr4_t dn);
        int t, rc, ph, rh, n, oph, orh;
        bit ok;
        predict(lk, dn, t, ok, rc, ph, rh);
        lk_a = lk;
        dn_a = dn;
        falls = 0;
        n = 0; oph = 0; orh = 0;
        while (!(ready || fault) && n < BOUND) begin
            if (pll_reset) oph++;
            if (rx_reset == '1) orh++;
            cyc();
            n++;
        end
        chk({tag, ".cycles"}, n, t);
        chk({tag, ".ready"}, ready, ok);
        chk({tag, ".fault"}, fault, !ok);
        chk({tag, ".retry"}, retry_cnt, rc);
        chk({tag, ".state"}, state, ok ? 5 : 6);
        chk({tag, ".pll_hi"}, oph, ph);
        chk({tag, ".rx_hi"}, orh, rh);
    endtask

    task automatic begin_seq();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        arr4_t lk, dn;
        int k;
        rst = 1'b1; start = 1'b0; pll_lock = 1'b0; rx_resetdone = '0;
        mask = '0; s_cnt = 0; rs_cnt = 0; falls = 0; was_rst = 1'b1;
        lk_a = '{2000, 2000, 2000, 2000};
        dn_a = '{2000, 2000, 2000, 2000};
        repeat (3) cyc();
        chk("rst.state", state, 0);
        chk("rst.pll_reset", pll_reset, 1);
        chk("rst.rx_reset", rx_reset, 8'hFF);
        chk("rst.ready", ready, 0);
        chk("rst.fault", fault, 0);
        chk("rst.retry", retry_cnt, 0);
        start = 1'b1;
        cyc();
        chk("rst_over_start.state", state, 0);
        start = 1'b0;

        // nominal bring-up
        begin_seq();
        chk("nom.first", state, 1);
        mask = 8'h00;
        lk = '{50, 50, 50, 50};
        dn = '{20, 20, 20, 20};
        run_seq("nom", lk, dn);

        // PLL never locks: retries exhaust into fault
        begin_seq();
        lk = '{2000, 2000, 2000, 2000};
        run_seq("nolock", lk, dn);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("fault_restart.state", state, 1);
        chk("fault_restart.fault", fault, 0);
        chk("fault_restart.retry", retry_cnt, 0);
        lk = '{10, 10, 10, 10};
        run_seq("after_fault", lk, dn);

        // one channel stuck for the first attempt
        begin_seq();
        mask = 8'h7F;
        lk = '{10, 10, 10, 10};
        dn = '{2000, 20, 20, 20};
        run_seq("done_to", lk, dn);

        // loss of lock in READY
        pll_lock = 1'b0;
        cyc();
        chk("lol.ready", ready, 0);
        chk("lol.state", state, 1);
        chk("lol.retry", retry_cnt, 0);
        dn = '{30, 30, 30, 30};
        run_seq("lol", lk, dn);

        // timeout boundaries
        begin_seq();
        lk = '{1024, 1023, 5, 5};
        dn = '{0, 0, 0, 0};
        run_seq("lock_edge", lk, dn);
        begin_seq();
        lk = '{5, 5, 5, 5};
        dn = '{1024, 1023, 0, 0};
        run_seq("done_edge", lk, dn);

        // reset mid RX_RST, then start ignored in WAIT_LOCK
        begin_seq();
        falls = 0;
        lk_a = '{100, 100, 100, 100};
        dn_a = '{20, 20, 20, 20};
        k = 0;
        while (state != 3 && k < BOUND) begin cyc(); k++; end
        chk("midrst.reach", state, 3);
        repeat (8) cyc();
        rst = 1'b1;
        cyc();
        chk("midrst.state", state, 0);
        chk("midrst.rx_reset", rx_reset, 8'hFF);
        chk("midrst.pll_reset", pll_reset, 1);
        rst = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        falls = 0;
        k = 0;
        while (state != 2 && k < BOUND) begin cyc(); k++; end
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("ign_start.state", state, 2);
        k = 0;
        while (!ready && k < BOUND) begin cyc(); k++; end
        chk("ign_start.ready", ready, 1);
        chk("ign_start.retry", retry_cnt, 0);

        // randomized attempt timings
        for (int r = 0; r < 5; r++) begin
            begin_seq();
            mask = N_CH'($urandom_range(0, 254));
            for (int a = 0; a < 4; a++) begin
                lk[a] = ($urandom_range(0, 3) == 0) ? 1500 : int'($urandom_range(0, 300));
                dn[a] = ($urandom_range(0, 3) == 0) ? 1500 : int'($urandom_range(0, 300));
            end
            run_seq($sformatf("rnd%0d", r), lk, dn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
